// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between the IF and MEM pipeline stages.
// Data accesses win over fetches; the pipeline stalls until every pending requester is served.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  input  logic        d_read_i,
  input  logic        d_write_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  localparam int unsigned CntW = 10;

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t          state, stateNext;
  logic            dDone, iDone;
  logic [CntW-1:0] waitCnt;
  logic            dPend, iPend;
  logic            startD, startI;
  logic            timeoutHit, accDone;

  assign dPend      = (d_read_i | d_write_i) & ~dDone;
  assign iPend      = if_req_i & ~iDone;
  assign stall_o    = dPend | iPend;
  assign startD     = (state == IDLE) & dPend;
  assign startI     = (state == IDLE) & ~dPend & iPend;
  // Last allowed wait cycle without an ack force-completes the access.
  assign timeoutHit = ~mem_ack_i & (waitCnt == CntW'(TIMEOUT - 1));
  assign accDone    = mem_ack_i | timeoutHit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (dPend)      stateNext = D_ACC;
        else if (iPend) stateNext = I_ACC;
      end
      D_ACC, I_ACC: begin
        if (accDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Memory-side request registers, held stable for the whole access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      waitCnt     <= '0;
    end else begin
      mem_req_o <= (stateNext != IDLE);
      if (startD) begin
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
        mem_we_o    <= d_write_i;
      end else if (startI) begin
        mem_addr_o <= if_addr_i;
        mem_we_o   <= 1'b0;
      end
      if (state == IDLE)   waitCnt <= '0;
      else if (!mem_ack_i) waitCnt <= waitCnt + CntW'(1);
    end
  end

  // Read-data capture, error flag and per-requester done flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      d_rdata_o  <= '0;
      if_rdata_o <= '0;
      err_o      <= 1'b0;
      dDone      <= 1'b0;
      iDone      <= 1'b0;
    end else begin
      if (state == D_ACC && accDone && !mem_we_o)
        d_rdata_o <= mem_ack_i ? mem_rdata_i : 32'h0;
      if (state == I_ACC && accDone)
        if_rdata_o <= mem_ack_i ? mem_rdata_i : 32'h0;
      if (state != IDLE && timeoutHit)
        err_o <= 1'b1;
      if (!stall_o) begin
        dDone <= 1'b0;
        iDone <= 1'b0;
      end else begin
        if (state == D_ACC && accDone) dDone <= 1'b1;
        if (state == I_ACC && accDone) iDone <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset-abort sequence and
// randomized pipeline steps checked against an access-level reference model.
module tb_mem_arbiter;

  localparam int unsigned TO  = 4;
  localparam int          TOI = int'(TO);

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        d_read_i, d_write_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // One pipeline step: requests presented, memory latencies, expected results.
  typedef struct {
    logic        rd, wr;
    logic [31:0] dAddr, dWdata, dRdata;
    int          dLat;
    logic        ifr;
    logic [31:0] iAddr, iRdata;
    int          iLat;
    int          expStall;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we, isData;
    int          lat;
  } acc_t;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] expDR   = 32'h0;
  logic [31:0] expIR   = 32'h0;
  logic        errModel = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Cycles an access occupies the memory: ack on cycle lat+1, or forced end at TO.
  function automatic int accCycles(input int lat);
    return (lat + 1 < TOI) ? lat + 1 : TOI;
  endfunction

  function automatic logic timedOut(input int lat);
    return (lat + 1 > TOI);
  endfunction

  // Fill in the expected stall length and error flag from the access rules.
  function automatic vec_t predict(input vec_t v, input logic errIn);
    vec_t r = v;
    r.expStall = 0;
    r.expErr   = errIn;
    if (v.rd | v.wr) begin
      r.expStall += 1 + accCycles(v.dLat);
      if (timedOut(v.dLat)) r.expErr = 1'b1;
    end
    if (v.ifr) begin
      r.expStall += 1 + accCycles(v.iLat);
      if (timedOut(v.iLat)) r.expErr = 1'b1;
    end
    return r;
  endfunction

  // Present one step at a negedge, act as the memory until the pipeline advances.
  task automatic runOp(input vec_t v, input string name);
    acc_t acc[$];
    acc_t cur;
    int   qi = 0, accCyc = 0, nReq = 0, stallCyc = 0;
    logic prevReq = 1'b0, bad = 1'b0, ended = 1'b0;
    cur = '{addr:32'h0, wdata:32'h0, rdata:32'h0, we:1'b0, isData:1'b0, lat:0};
    if (v.rd | v.wr)
      acc.push_back('{addr:v.dAddr, wdata:v.dWdata, rdata:v.dRdata, we:v.wr, isData:1'b1, lat:v.dLat});
    if (v.ifr)
      acc.push_back('{addr:v.iAddr, wdata:32'h0, rdata:v.iRdata, we:1'b0, isData:1'b0, lat:v.iLat});
    d_read_i  = v.rd;
    d_write_i = v.wr;
    d_addr_i  = v.dAddr;
    d_wdata_i = v.dWdata;
    if_req_i  = v.ifr;
    if_addr_i = v.iAddr;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (mem_req_o) begin
        if (!prevReq) begin
          nReq++;
          if (qi < acc.size()) begin
            cur = acc[qi];
            qi++;
          end
          accCyc = 0;
        end
        accCyc++;
        if (mem_addr_o !== cur.addr || mem_we_o !== cur.we || (cur.we && mem_wdata_o !== cur.wdata))
          bad = 1'b1;
        mem_ack_i   = (accCyc == cur.lat + 1);
        mem_rdata_i = mem_ack_i ? cur.rdata : $urandom();
      end else begin
        // Stray acks while idle must be ignored.
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom();
      end
      prevReq = mem_req_o;
      if (!stall_o) begin
        ended = 1'b1;
        break;
      end
      stallCyc++;
      @(negedge clk_i);
    end
    foreach (acc[i]) begin
      if (acc[i].isData && !acc[i].we) expDR = timedOut(acc[i].lat) ? 32'h0 : acc[i].rdata;
      if (!acc[i].isData)              expIR = timedOut(acc[i].lat) ? 32'h0 : acc[i].rdata;
    end
    errModel = v.expErr;
    check({name, ".advanced"}, 32'(ended), 32'd1);
    check({name, ".stallCycles"}, 32'(stallCyc), 32'(v.expStall));
    check({name, ".numRequests"}, 32'(nReq), 32'(acc.size()));
    check({name, ".reqFields"}, 32'(bad), 32'd0);
    check({name, ".d_rdata"}, d_rdata_o, expDR);
    check({name, ".if_rdata"}, if_rdata_o, expIR);
    check({name, ".err"}, 32'(err_o), 32'(v.expErr));
    @(negedge clk_i);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    //        rd wr dAddr       dWdata        dRdata        dLat ifr iAddr     iRdata        iLat stall err
    tbl[0] = '{0, 0, 32'h0,     32'h0,        32'h0,        0,   1, 32'h100, 32'h00A00093, 0,   2,    0};
    tbl[1] = '{1, 0, 32'h40,    32'h0,        32'h11112222, 2,   1, 32'h104, 32'h33334444, 2,   8,    0};
    tbl[2] = '{1, 1, 32'h80,    32'hDEADBEEF, 32'h55556666, 1,   0, 32'h0,   32'h0,        0,   3,    0};
    tbl[3] = '{1, 0, 32'h10,    32'h0,        32'hA0A0A0A0, 0,   0, 32'h0,   32'h0,        0,   2,    0};
    tbl[4] = '{1, 0, 32'h14,    32'h0,        32'hB1B1B1B1, 0,   0, 32'h0,   32'h0,        0,   2,    0};
    tbl[5] = '{1, 0, 32'h20,    32'h0,        32'hC2C2C2C2, 0,   1, 32'h108, 32'hD3D3D3D3, 0,   4,    0};
    tbl[6] = '{1, 0, 32'h24,    32'h0,        32'hE4E4E4E4, 3,   0, 32'h0,   32'h0,        0,   5,    0};
    tbl[7] = '{1, 0, 32'h28,    32'h0,        32'hF5F5F5F5, 9,   0, 32'h0,   32'h0,        0,   5,    1};
    tbl[8] = '{0, 0, 32'h0,     32'h0,        32'h0,        0,   1, 32'h10C, 32'h01020304, 1,   3,    1};
    tbl[9] = '{0, 0, 32'h0,     32'h0,        32'h0,        0,   0, 32'h0,   32'h0,        0,   0,    1};

    rst_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    d_read_i = 1'b0; d_write_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    check("reset.mem_req", 32'(mem_req_o), 32'd0);
    check("reset.mem_we", 32'(mem_we_o), 32'd0);
    check("reset.mem_addr", mem_addr_o, 32'h0);
    check("reset.mem_wdata", mem_wdata_o, 32'h0);
    check("reset.rdata", d_rdata_o | if_rdata_o, 32'h0);
    check("reset.err", 32'(err_o), 32'd0);
    check("reset.stall", 32'(stall_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 10; i++) runOp(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a data access, then an ack that must be ignored.
    d_read_i = 1'b1; d_addr_i = 32'h200; mem_ack_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("rstMid.inAccess", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    d_read_i = 1'b0;
    #1;
    check("rstMid.mem_req", 32'(mem_req_o), 32'd0);
    check("rstMid.mem_addr", mem_addr_o, 32'h0);
    check("rstMid.err", 32'(err_o), 32'd0);
    check("rstMid.d_rdata", d_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hBADBAD00;
    repeat (3) @(negedge clk_i);
    #1;
    check("rstMid.ackIgnored.req", 32'(mem_req_o), 32'd0);
    check("rstMid.ackIgnored.d_rdata", d_rdata_o, 32'h0);
    check("rstMid.ackIgnored.if_rdata", if_rdata_o, 32'h0);
    check("rstMid.stall", 32'(stall_o), 32'd0);
    mem_ack_i = 1'b0;
    expDR = 32'h0;
    expIR = 32'h0;
    errModel = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 40; i++) begin
      rv.rd     = 1'($urandom_range(0, 1));
      rv.wr     = 1'($urandom_range(0, 1));
      rv.dAddr  = $urandom() & 32'h0000FFFC;
      rv.dWdata = $urandom();
      rv.dRdata = $urandom();
      rv.dLat   = int'($urandom_range(0, 5));
      rv.ifr    = 1'($urandom_range(0, 1));
      rv.iAddr  = $urandom() & 32'h0000FFFC;
      rv.iRdata = $urandom();
      rv.iLat   = int'($urandom_range(0, 5));
      rv = predict(rv, errModel);
      runOp(rv, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles to wait for mem_ack_i before an access is force-completed (range 1..1023).
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 if_req_i  in  1  IF stage requests instruction fetch this cycle.
REQ-005 if_addr_i  in  32  fetch address; held stable by IF while stall_o=1.
REQ-006 if_rdata_o  out  32  fetched instruction word, registered.
REQ-007 d_read_i / d_write_i  in  1 each  MEM stage load / store request (EX/MEM MemRead/MemWrite).
REQ-008 d_addr_i, d_wdata_i  in  32 each  data address (EX/MEM ALU result) and store data; held stable while stall_o=1.
REQ-009 d_rdata_o  out  32  load data, registered.
REQ-010 stall_o  out  1  global pipeline freeze; drives memStall_i of all pipeline registers.
REQ-011 mem_req_o, mem_we_o  out  1 each  shared memory request / write enable.
REQ-012 mem_addr_o, mem_wdata_o  out  32 each  shared memory address / write data.
REQ-013 mem_rdata_i  in  32, mem_ack_i  in  1  memory read data / completion, valid in the same cycle.
REQ-014 err_o  out  1  sticky: at least one access timed out.

Function
REQ-015 FSM states: IDLE, D_ACC, I_ACC; mem_req_o=1 exactly in D_ACC and I_ACC.
REQ-016 d_pend = (d_read_i|d_write_i) & ~d_done; i_pend = if_req_i & ~i_done; d_done, i_done are internal registered flags.
REQ-017 stall_o = d_pend | i_pend, combinational.
REQ-018 IDLE: if d_pend -> D_ACC; else if i_pend -> I_ACC; else stay. Data has strict priority over fetch.
REQ-019 On entry to D_ACC: mem_addr_o<=d_addr_i, mem_wdata_o<=d_wdata_i, mem_we_o<=d_write_i; if d_read_i and d_write_i are both 1, the access is a write.
REQ-020 On entry to I_ACC: mem_addr_o<=if_addr_i, mem_we_o<=0, mem_wdata_o unchanged.
REQ-021 mem_addr_o, mem_wdata_o, mem_we_o stable while mem_req_o=1.
REQ-022 D_ACC with mem_ack_i=1: -> IDLE, d_done<=1, d_rdata_o<=mem_rdata_i if read (unchanged on write).
REQ-023 I_ACC with mem_ack_i=1: -> IDLE, i_done<=1, if_rdata_o<=mem_rdata_i.
REQ-024 Done flags clear on any rising edge where stall_o=0 (pipeline advances); set-at-ack has priority only when stall_o=1 (cannot coincide, since stall_o=1 in any access state).
REQ-025 Zero-wait memory (ack in first D_ACC cycle): stall_o high 2 cycles for one data access, 4 cycles when data and fetch are both pending, 2 cycles for fetch only.
REQ-026 10-bit wait counter: cleared on entry to D_ACC/I_ACC, increments each access-state cycle without ack; when it reaches TIMEOUT without ack, the access completes as in REQ-022/023 with 0 captured as read data, and err_o<=1.
REQ-027 mem_ack_i in IDLE is ignored.
REQ-028 No new access starts for a requester whose done flag is set, so a granted access is never reissued during a stall held by the other requester.

Reset
REQ-029 rst_i=0 asynchronously forces: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if_rdata_o=0, d_rdata_o=0, d_done=0, i_done=0, wait counter 0, err_o=0.
REQ-030 Reset during D_ACC/I_ACC abandons the access; a following mem_ack_i is ignored; stall_o follows REQ-017 from cleared flags.

Verification
REQ-031 Fetch only, if_addr_i=0x100, ack in first I_ACC cycle, mem_rdata_i=0x00A00093 -> stall_o high 2 cycles, if_rdata_o=0x00A00093, mem_we_o=0.
REQ-032 Load d_addr_i=0x40 and fetch 0x104 together, each acked after 3 cycles -> D_ACC precedes I_ACC, stall_o high until both done, no access reissued, then falls for one cycle.
REQ-033 Store d_read_i=d_write_i=1, d_addr_i=0x80, d_wdata_i=0xDEADBEEF -> mem_we_o=1 and mem_wdata_o=0xDEADBEEF stable until ack; d_rdata_o unchanged.
REQ-034 TIMEOUT=4, load with no ack -> completes after 4 cycles, d_rdata_o=0, err_o=1 and held through later good accesses.
REQ-035 rst_i pulsed low mid D_ACC, ack asserted afterward -> all outputs at reset values, mem_req_o=0, ack ignored, err_o=0.
REQ-036 Back-to-back loads on consecutive advances (0x10 then 0x14) -> two distinct memory requests, d_rdata_o updated once per load.
